sound_mixer: RTL and testbench
==============================

SOUND_MIXER -- requirements
Module: sound_mixer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, giving the number of mixed channels (1..8).
REQ-002 SHALL have parameter LEVEL_W, default 4, giving the per-channel level width.
REQ-003 SHALL have parameter OUT_W, default 16, giving the output sample width; OUT_W >= SCALED_W, where SCALED_W = LEVEL_W + $clog2(NUM_CH) + 3 (minimum 1 for the clog2 term).
REQ-004 SHALL have a single clock and an asynchronous, active-low reset.
REQ-005 Port: ac97_bitclk  in  1  sole clock; all logic is rising-edge.
REQ-006 Port: reset_b  in  1  asynchronous active-low reset.
REQ-007 Port: strobe  in  1  one-cycle sample request.
REQ-008 Port: ch_levels  in  NUM_CH*LEVEL_W  channel i occupies bits [i*LEVEL_W +: LEVEL_W], unsigned.
REQ-009 Port: so1_enable, so2_enable  in  NUM_CH each  per-channel routing to SO1 (left) and SO2 (right).
REQ-010 Port: so1_output_level, so2_output_level  in  3 each  master volume per side; gain = value+1.
REQ-011 Port: master_sound_enable  in  1  global enable.
REQ-012 Port: left_sample, right_sample  out  OUT_W each  two's-complement mixed samples.
REQ-013 Port: sample_valid  out  1  one-cycle pulse when new samples are presented.
REQ-014 Port: busy  out  1  high whenever state != IDLE.
REQ-015 Port: overrun_count  out  8  saturating count of dropped strobes.

Function
REQ-016 SHALL implement FSM IDLE -> ACCUM -> SCALE -> DONE -> IDLE.
REQ-017 IDLE: on a strobe=1 edge, snapshot ch_levels, both enable vectors, both output levels and master_sound_enable; clear both accumulators and the channel index; go to ACCUM.
REQ-018 ACCUM: one channel per edge, index 0..NUM_CH-1; add that channel's level to the left accumulator if its so1_enable bit is set, and to the right accumulator if its so2_enable bit is set. Go to SCALE after index NUM_CH-1.
REQ-019 Accumulators SHALL be LEVEL_W+$clog2(NUM_CH) bits wide and SHALL never overflow.
REQ-020 SCALE: each side's sum is multiplied by (snapshot output_level+1) into SCALED_W bits; go to DONE.
REQ-021 On entry to DONE, each side's sample SHALL be loaded as: scaled value left-aligned into OUT_W bits (low bits zero), then the MSB inverted (offset binary to two's complement).
REQ-022 If the snapshotted master_sound_enable is 0, both samples SHALL load as 0.
REQ-023 DONE: sample_valid=1 for exactly that cycle; then return to IDLE. Samples SHALL hold until the next DONE.
REQ-024 Latency: a strobe sampled at edge k SHALL produce sample_valid high in the cycle following edge k+NUM_CH+2. A strobe can be accepted again on the first edge after DONE.
REQ-025 A strobe=1 edge while state != IDLE SHALL be ignored for mixing and SHALL increment overrun_count, saturating at 255.
REQ-026 Input changes after the snapshot edge SHALL NOT affect the samples in flight.

Reset
REQ-027 reset_b=0 SHALL asynchronously force: state IDLE; sample_valid=0; busy=0; left_sample=0; right_sample=0; overrun_count=0; accumulators and index cleared.
REQ-028 Deassertion of reset_b mid-operation SHALL NOT produce sample_valid for the aborted request.

Configuration
REQ-029 Macro SOUND_MIXER_OVERRUN_COUNT_EN: when defined, REQ-025 counting is implemented.
REQ-030 When SOUND_MIXER_OVERRUN_COUNT_EN is undefined, overrun_count SHALL be constant 0 and dropped strobes are silently ignored; all other behaviour is unchanged.

Verification
REQ-031 Defaults; all levels=15; so1_enable=4'hF; so2_enable=0; both output levels=7; master=1; strobe at edge k -> sample_valid in the cycle after edge k+6; left_sample=16'h7000; right_sample=16'h8000.
REQ-032 ch0 level=8 only; so1_enable=4'h1; so1_output_level=0 -> left_sample=16'h8400.
REQ-033 Same as REQ-031 but master=0 -> both samples=16'h0000; sample_valid still pulses once.
REQ-034 Second strobe 2 cycles after the first -> one sample_valid; overrun_count=1; with 300 such strobes, overrun_count=255; with SOUND_MIXER_OVERRUN_COUNT_EN undefined, overrun_count=0.
REQ-035 Change ch_levels to 0 one cycle after an accepted strobe -> output equals the REQ-031 values (snapshot held).
REQ-036 Assert reset_b=0 while in ACCUM -> all outputs 0 immediately, without waiting for a clock edge; no sample_valid after release until a new strobe.

Source files
------------

// File: rtl/sound_mixer_if.sv
// Sample-request / mixed-sample bundle between a mixer client (master) and sound_mixer (slave).
interface sound_mixer_if #(
    parameter int NUM_CH  = 4,
    parameter int LEVEL_W = 4,
    parameter int OUT_W   = 16
);
    logic                      strobe;
    logic [NUM_CH*LEVEL_W-1:0] ch_levels;
    logic [NUM_CH-1:0]         so1_enable;
    logic [NUM_CH-1:0]         so2_enable;
    logic [2:0]                so1_output_level;
    logic [2:0]                so2_output_level;
    logic                      master_sound_enable;
    logic [OUT_W-1:0]          left_sample;
    logic [OUT_W-1:0]          right_sample;
    logic                      sample_valid;
    logic                      busy;
    logic [7:0]                overrun_count;

    modport master (
        output strobe, ch_levels, so1_enable, so2_enable,
               so1_output_level, so2_output_level, master_sound_enable,
        input  left_sample, right_sample, sample_valid, busy, overrun_count
    );

    modport slave (
        input  strobe, ch_levels, so1_enable, so2_enable,
               so1_output_level, so2_output_level, master_sound_enable,
        output left_sample, right_sample, sample_valid, busy, overrun_count
    );
endinterface

// File: rtl/sound_mixer.sv
// Sequential stereo mixer: snapshot, accumulate one channel per clock, scale, emit.
// Optional macro SOUND_MIXER_OVERRUN_COUNT_EN enables counting of strobes dropped while busy.
module sound_mixer #(
    parameter int NUM_CH  = 4,
    parameter int LEVEL_W = 4,
    parameter int OUT_W   = 16
) (
    input logic          ac97_bitclk,
    input logic          reset_b,
    sound_mixer_if.slave mix
);
    localparam int CLOG     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ACC_W    = LEVEL_W + CLOG;
    localparam int SCALED_W = ACC_W + 3;
    localparam int SHIFT    = OUT_W - SCALED_W;
    localparam logic [OUT_W-1:0] MSB = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, DONE} state_t;

    state_t                           state;
    logic [NUM_CH-1:0][LEVEL_W-1:0]   lvl_q;
    logic [1:0][NUM_CH-1:0]           en_q;
    logic [1:0][2:0]                  gain_q;
    logic                             master_q;
    logic [CLOG-1:0]                  idx;
    logic [1:0][ACC_W-1:0]            acc;
    logic [1:0][ACC_W-1:0]            acc_add;
    logic [1:0][SCALED_W-1:0]         scaled;
    logic [1:0][OUT_W-1:0]            sample_d;
    logic [OUT_W-1:0]                 left_q, right_q;
    logic                             valid_q, busy_q;

    // Side 0 is SO1/left, side 1 is SO2/right.
    for (genvar s = 0; s < 2; s++) begin : g_side
        assign acc_add[s]  = en_q[s][idx] ? ACC_W'(lvl_q[idx]) : '0;
        // Left-align the unsigned magnitude, then flip the MSB: offset binary -> two's complement.
        assign sample_d[s] = master_q ? ((OUT_W'(scaled[s]) << SHIFT) ^ MSB) : '0;
    end

    always_ff @(posedge ac97_bitclk or negedge reset_b) begin
        if (!reset_b) begin
            state    <= IDLE;
            lvl_q    <= '0;
            en_q     <= '0;
            gain_q   <= '0;
            master_q <= 1'b0;
            idx      <= '0;
            acc      <= '0;
            scaled   <= '0;
            left_q   <= '0;
            right_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (mix.strobe) begin
                        lvl_q    <= mix.ch_levels;
                        en_q     <= {mix.so2_enable, mix.so1_enable};
                        gain_q   <= {mix.so2_output_level, mix.so1_output_level};
                        master_q <= mix.master_sound_enable;
                        acc      <= '0;
                        idx      <= '0;
                        busy_q   <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    for (int s = 0; s < 2; s++) acc[s] <= acc[s] + acc_add[s];
                    if (idx == CLOG'(NUM_CH - 1)) state <= SCALE;
                    else                          idx   <= idx + 1'b1;
                end
                SCALE: begin
                    for (int s = 0; s < 2; s++)
                        scaled[s] <= SCALED_W'(acc[s]) * (SCALED_W'(gain_q[s]) + SCALED_W'(1));
                    state <= DONE;
                end
                DONE: begin
                    left_q  <= sample_d[0];
                    right_q <= sample_d[1];
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SOUND_MIXER_OVERRUN_COUNT_EN
    logic [7:0] ovr_q;

    always_ff @(posedge ac97_bitclk or negedge reset_b) begin
        if (!reset_b)                                        ovr_q <= '0;
        else if (mix.strobe && state != IDLE && ovr_q != 8'hFF) ovr_q <= ovr_q + 8'd1;
    end

    assign mix.overrun_count = ovr_q;
`else
    assign mix.overrun_count = 8'd0;
`endif

    assign mix.left_sample  = left_q;
    assign mix.right_sample = right_q;
    assign mix.sample_valid = valid_q;
    assign mix.busy         = busy_q;
endmodule

// File: tb/tb_sound_mixer.sv
// Scoreboard bench for sound_mixer: transaction-level model predicts accepts, drops and samples.
module tb_sound_mixer;
    localparam int NUM_CH  = 4;
    localparam int LEVEL_W = 4;
    localparam int OUT_W   = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sound_mixer_if #(.NUM_CH(NUM_CH), .LEVEL_W(LEVEL_W), .OUT_W(OUT_W)) bus ();
    sound_mixer #(.NUM_CH(NUM_CH), .LEVEL_W(LEVEL_W), .OUT_W(OUT_W)) dut (
        .ac97_bitclk(clk), .reset_b(rst_n), .mix(bus)
    );

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          cyc;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          free_edge = 0;
    int          ovr_ref = 0;
    logic [15:0] last_l = '0, last_r = '0;
    logic        mon_on = 1'b0;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sum of routed levels, times gain, placed at full scale of a 16-bit offset-binary word
    // (9 significant bits for the default parameters, so a factor of 2^7), then sign-converted.
    function automatic logic [15:0] mix_ref(input logic [15:0] lv, input logic [3:0] en,
                                            input logic [2:0] g, input logic m);
        int sum = 0;
        for (int i = 0; i < NUM_CH; i++) if (en[i]) sum += int'(lv[i*4 +: 4]);
        if (!m) return 16'h0000;
        return 16'(sum * (int'(g) + 1) * 128) ^ 16'h8000;
    endfunction

    function automatic int ovr_exp();
`ifdef SOUND_MIXER_OVERRUN_COUNT_EN
        return ovr_ref;
`else
        return 0;
`endif
    endfunction

    task automatic issue(input logic st, input logic [15:0] lv, input logic [3:0] e1,
                         input logic [3:0] e2, input logic [2:0] g1, input logic [2:0] g2,
                         input logic m, input logic use_k, input logic [15:0] kl,
                         input logic [15:0] kr);
        int   edge_n;
        exp_t e;
        bus.strobe = st; bus.ch_levels = lv; bus.so1_enable = e1; bus.so2_enable = e2;
        bus.so1_output_level = g1; bus.so2_output_level = g2; bus.master_sound_enable = m;
        edge_n = cyc + 1;
        if (st) begin
            if (edge_n >= free_edge) begin
                e.l   = use_k ? kl : mix_ref(lv, e1, g1, m);
                e.r   = use_k ? kr : mix_ref(lv, e2, g2, m);
                e.cyc = edge_n + NUM_CH + 2;
                q.push_back(e);
                free_edge = edge_n + NUM_CH + 3;
            end else if (ovr_ref < 255) begin
                ovr_ref++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic tick();
        bus.strobe = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (q.size() != 0 && k < 40) begin tick(); k++; end
        check(name, q.size(), 0);
        q.delete();
        tick();
    endtask

    task automatic reset_model();
        q.delete();
        free_edge = 0;
        ovr_ref   = 0;
        last_l    = '0;
        last_r    = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_left"},  bus.left_sample,   0);
        check({tag, "_right"}, bus.right_sample,  0);
        check({tag, "_valid"}, bus.sample_valid,  0);
        check({tag, "_busy"},  bus.busy,          0);
        check({tag, "_ovr"},   bus.overrun_count, 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check_zero("reset");
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_on) begin
            if (bus.sample_valid) begin
                if (q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_valid: got valid with no request pending (t=%0t)", $time);
                end else begin
                    mon_e = q.pop_front();
                    check("left_sample",  bus.left_sample,  mon_e.l);
                    check("right_sample", bus.right_sample, mon_e.r);
                    check("latency_cyc",  cyc,              mon_e.cyc);
                    last_l = mon_e.l;
                    last_r = mon_e.r;
                end
            end else begin
                check("hold_left",  bus.left_sample,  last_l);
                check("hold_right", bus.right_sample, last_r);
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        bus.strobe = 0; bus.ch_levels = 0; bus.so1_enable = 0; bus.so2_enable = 0;
        bus.so1_output_level = 0; bus.so2_output_level = 0; bus.master_sound_enable = 0;
        #1 rst_n = 1'b0;
        #1 check_zero("por");
        reset_model();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        mon_on = 1'b1;

        // Full-scale left, silent right.
        issue(1, 16'hFFFF, 4'hF, 4'h0, 3'd7, 3'd7, 1, 1, 16'h7000, 16'h8000);
        check("busy_after_accept", bus.busy, 1);
        drain("drain_full");
        // Single channel at unity gain.
        issue(1, 16'h0008, 4'h1, 4'h0, 3'd0, 3'd0, 1, 1, 16'h8400, 16'h8000);
        drain("drain_single");
        // Master disabled still pulses valid with zero samples.
        issue(1, 16'hFFFF, 4'hF, 4'h0, 3'd7, 3'd7, 0, 1, 16'h0000, 16'h0000);
        drain("drain_mute");
        // Inputs dropped to zero right after the accepting edge must not disturb the result.
        issue(1, 16'hFFFF, 4'hF, 4'h0, 3'd7, 3'd7, 1, 1, 16'h7000, 16'h8000);
        bus.ch_levels = 16'h0000; bus.so1_enable = 4'h0;
        tick();
        drain("drain_snapshot");

        // One overlapping strobe two cycles after an accepted one.
        pulse_reset();
        issue(1, 16'hFFFF, 4'hF, 4'h0, 3'd7, 3'd7, 1, 1, 16'h7000, 16'h8000);
        tick();
        issue(1, 16'h0000, 4'h0, 4'h0, 3'd0, 3'd0, 1, 0, 16'h0, 16'h0);
        drain("drain_overrun1");
        check("overrun_one", bus.overrun_count, ovr_exp());

        // Continuous strobes saturate the counter.
        for (int i = 0; i < 300; i++) issue(1, 16'hFFFF, 4'hF, 4'h0, 3'd7, 3'd7, 1, 0, 16'h0, 16'h0);
        drain("drain_sat");
        check("overrun_sat", bus.overrun_count, ovr_exp());

        // Asynchronous reset in the middle of accumulation.
        issue(1, 16'hFFFF, 4'hF, 4'hF, 3'd7, 3'd7, 1, 0, 16'h0, 16'h0);
        tick();
        #2;
        pulse_reset();
        for (int i = 0; i < 12; i++) tick();
        check("no_valid_after_abort", q.size(), 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            issue($urandom_range(0, 3) == 0, 16'($urandom), 4'($urandom), 4'($urandom),
                  3'($urandom), 3'($urandom), $urandom_range(0, 7) != 0, 0, 16'h0, 16'h0);
        drain("drain_random");
        check("overrun_random", bus.overrun_count, ovr_exp());

        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
